// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall/flush controller for a 5-stage pipeline (load-use, memory
//             wait, multi-cycle MDU) with a saturating stall-cycle counter.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_re1,
  input  logic [REG_ADDR_W-1:0] id_raddr1,
  input  logic                  id_re2,
  input  logic [REG_ADDR_W-1:0] id_raddr2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_wd_addr,
  input  logic                  ex_mdu_start,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  write_pc_ir,
  output logic                  branch,
  output logic                  id_ex_hold,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_hold,
  output logic                  ex_mem_bubble,
  output logic                  mem_wb_bubble,
  output logic                  mdu_done,
  output logic [31:0]           stall_cnt
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_mdu_load = CNT_W'(MDU_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic w_mem_stall;
  logic w_lu;
  logic w_cnt_zero;
  logic w_mdu_stall;
  logic w_mdu_fin;

  always_comb begin
    w_mem_stall = mem_req & ~mem_ack;
    w_lu        = ex_mem_read & (ex_wd_addr != '0) &
                  ((id_re1 & (id_raddr1 == ex_wd_addr)) |
                   (id_re2 & (id_raddr2 == ex_wd_addr)));
    w_cnt_zero  = (cnt_q == '0);
    w_mdu_stall = ((state_q == ST_RUN) & ex_mdu_start) |
                  ((state_q == ST_MDU_BUSY) & ~w_cnt_zero);
    w_mdu_fin   = (state_q == ST_MDU_BUSY) & ~w_mem_stall & w_cnt_zero;
  end

  // Priority: memory wait > MDU occupancy > load-use > branch flush.
  always_comb begin
    write_pc_ir   = 1'b0;
    branch        = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    mdu_done      = 1'b0;
    if (rst_n) begin
      mdu_done = w_mdu_fin;
      if (w_mem_stall) begin
        write_pc_ir   = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (w_mdu_stall) begin
        write_pc_ir   = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_bubble = 1'b1;
      end else if (w_lu) begin
        write_pc_ir  = 1'b1;
        id_ex_bubble = 1'b1;
      end else begin
        branch = branch_taken;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_mdu_start && !w_mem_stall) begin
          state_d = ST_MDU_BUSY;
          cnt_d   = c_mdu_load;
        end
      end
      ST_MDU_BUSY: begin
        // A memory wait freezes the MDU countdown along with the pipeline.
        if (!w_mem_stall) begin
          if (w_cnt_zero) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (write_pc_ir && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed scoreboard bench for pipe_ctrl (MDU_CYCLES = 4).
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int REG_ADDR_W = 5;

  // Control bit order: write_pc_ir, branch, id_ex_hold, id_ex_bubble,
  // ex_mem_hold, ex_mem_bubble, mem_wb_bubble, mdu_done
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_LU   = 8'b1001_0000;
  localparam logic [7:0] E_BR   = 8'b0100_0000;
  localparam logic [7:0] E_MDU  = 8'b1010_0100;
  localparam logic [7:0] E_MEM  = 8'b1010_1010;
  localparam logic [7:0] E_DONE = 8'b0000_0001;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [31:0] cnt;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  id_re1, id_re2;
  logic [REG_ADDR_W-1:0] id_raddr1, id_raddr2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_wd_addr;
  logic                  ex_mdu_start;
  logic                  branch_taken;
  logic                  mem_req, mem_ack;
  logic                  write_pc_ir, branch, id_ex_hold, id_ex_bubble;
  logic                  ex_mem_hold, ex_mem_bubble, mem_wb_bubble, mdu_done;
  logic [31:0]           stall_cnt;

  exp_t        sb_q[$];
  logic [31:0] exp_stall;
  int          checks = 0;
  int          errors = 0;

  pipe_ctrl #(
    .REG_ADDR_W (REG_ADDR_W),
    .MDU_CYCLES (4),
    .CNT_W      (6)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_re1        (id_re1),
    .id_raddr1     (id_raddr1),
    .id_re2        (id_re2),
    .id_raddr2     (id_raddr2),
    .ex_mem_read   (ex_mem_read),
    .ex_wd_addr    (ex_wd_addr),
    .ex_mdu_start  (ex_mdu_start),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .write_pc_ir   (write_pc_ir),
    .branch        (branch),
    .id_ex_hold    (id_ex_hold),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_hold   (ex_mem_hold),
    .ex_mem_bubble (ex_mem_bubble),
    .mem_wb_bubble (mem_wb_bubble),
    .mdu_done      (mdu_done),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_re1       = 1'b0;
    id_re2       = 1'b0;
    id_raddr1    = '0;
    id_raddr2    = '0;
    ex_mem_read  = 1'b0;
    ex_wd_addr   = '0;
    ex_mdu_start = 1'b0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ack      = 1'b0;
  endtask

  task automatic check_step(input string tag);
    exp_t       e;
    logic [7:0] obs;
    e   = sb_q.pop_front();
    obs = {write_pc_ir, branch, id_ex_hold, id_ex_bubble,
           ex_mem_hold, ex_mem_bubble, mem_wb_bubble, mdu_done};
    checks++;
    assert (obs === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl: observed %b expected %b", tag, obs, e.ctl);
    end
    checks++;
    assert (stall_cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s stall_cnt: observed %h expected %h", tag, stall_cnt, e.cnt);
    end
  endtask

  // Inputs are already driven (just after negedge); push expectation,
  // compare once settled, then advance one clock and update the count model.
  task automatic step(input string tag, input logic [7:0] exp_ctl);
    sb_q.push_back({exp_ctl, exp_stall});
    #1;
    check_step(tag);
    @(posedge clk);
    if (!rst_n) begin
      exp_stall = '0;
    end else if (exp_ctl[7] && exp_stall != 32'hFFFF_FFFF) begin
      exp_stall = exp_stall + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    exp_stall = '0;
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset forces outputs low even with stall-causing inputs
    mem_req = 1'b1; ex_mdu_start = 1'b1;
    step("reset_hold", E_NONE);
    clear_inputs(); rst_n = 1'b1;
    step("idle", E_NONE);

    // Load-use on port 1, single bubble
    ex_mem_read = 1'b1; ex_wd_addr = 5'd5; id_re1 = 1'b1; id_raddr1 = 5'd5;
    step("lu_p1", E_LU);
    clear_inputs();
    step("lu_p1_after", E_NONE);

    // Address 0 never hazards
    ex_mem_read = 1'b1; ex_wd_addr = 5'd0; id_re1 = 1'b1; id_raddr1 = 5'd0;
    step("lu_addr0", E_NONE);

    // Load-use on port 2, then same addresses with read-enable low
    clear_inputs();
    ex_mem_read = 1'b1; ex_wd_addr = 5'd7; id_re2 = 1'b1; id_raddr2 = 5'd7;
    step("lu_p2", E_LU);
    id_re2 = 1'b0;
    step("lu_p2_noren", E_NONE);

    // Branch suppressed under stall, then taken
    ex_mem_read = 1'b1; ex_wd_addr = 5'd9; id_re1 = 1'b1; id_raddr1 = 5'd9;
    branch_taken = 1'b1;
    step("br_vs_lu", E_LU);
    clear_inputs(); branch_taken = 1'b1;
    step("br_taken", E_BR);
    clear_inputs();

    // MDU: 4 held cycles then done
    ex_mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) step("mdu_busy", E_MDU);
    step("mdu_done", E_DONE);
    ex_mdu_start = 1'b0;
    step("mdu_after", E_NONE);

    // Memory wait inside an MDU op stretches it by two cycles
    ex_mdu_start = 1'b1;
    step("mdum_c0", E_MDU);
    mem_req = 1'b1; mem_ack = 1'b0;
    step("mdum_c1", E_MEM);
    step("mdum_c2", E_MEM);
    mem_ack = 1'b1;
    step("mdum_c3_ack", E_MDU);
    mem_req = 1'b0; mem_ack = 1'b0;
    step("mdum_c4", E_MDU);
    step("mdum_c5", E_MDU);
    step("mdum_c6_done", E_DONE);
    ex_mdu_start = 1'b0;
    step("mdum_after", E_NONE);

    // Start is not accepted while memory is stalling
    ex_mdu_start = 1'b1; mem_req = 1'b1;
    step("mdu_start_memwait", E_MEM);
    mem_req = 1'b0;
    for (int i = 0; i < 4; i++) step("mdu_late_busy", E_MDU);
    step("mdu_late_done", E_DONE);
    ex_mdu_start = 1'b0;
    step("mdu_late_after", E_NONE);

    // Reset mid-MDU abandons the op without a done pulse
    ex_mdu_start = 1'b1;
    step("rst_mdu_c0", E_MDU);
    step("rst_mdu_c1", E_MDU);
    rst_n = 1'b0;
    step("rst_mdu_c2", E_NONE);
    rst_n = 1'b1; ex_mdu_start = 1'b0;
    step("rst_mdu_release", E_NONE);
    ex_mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) step("rst_mdu_restart", E_MDU);
    step("rst_mdu_restart_done", E_DONE);
    ex_mdu_start = 1'b0;
    step("rst_mdu_restart_after", E_NONE);

    // Saturation: preload counter close to its ceiling, then stall on memory
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFD;
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) step("sat_memwait", E_MEM);
    mem_req = 1'b0;
    step("sat_final", E_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
